// File: rtl/user_id_readout.sv
// Shadow register and access sequencer for the 32-bit mask revision / user ID word.
// Captures after reset settles or on refresh, then serves bus reads and MSB-first serial shift-out.
module user_id_readout #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CLKDIV        = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] mask_rev,
  input  logic        refresh,
  output logic        id_valid,
  input  logic        rd_req,
  output logic        rd_ack,
  output logic [31:0] rd_data,
  input  logic        ser_start,
  output logic        ser_busy,
  output logic        ser_out,
  output logic        ser_strobe,
  output logic        ser_done
);

  typedef enum logic [1:0] {ST_WAIT, ST_CAPTURE, ST_IDLE, ST_SHIFT} state_t;

  localparam logic [7:0] SETTLE_LIM = 8'(SETTLE_CYCLES);
  localparam logic [7:0] DIV_LAST   = 8'(CLKDIV - 1);

  state_t      state_q,    state_d;
  logic [7:0]  settle_q,   settle_d;
  logic [31:0] shadow_q,   shadow_d;
  logic        id_valid_q, id_valid_d;
  logic        pending_q,  pending_d;
  logic [31:0] shift_q,    shift_d;
  logic [4:0]  bit_q,      bit_d;
  logic [7:0]  div_q,      div_d;
  logic        rd_ack_q,   rd_ack_d;
  logic [31:0] rd_data_q,  rd_data_d;
  logic        rd_armed_q, rd_armed_d;

  // Serial outputs decode directly from state so an async reset silences them at once.
  assign ser_busy   = (state_q == ST_SHIFT);
  assign ser_out    = ser_busy & shift_q[31];
  assign ser_strobe = ser_busy && (div_q == DIV_LAST);
  assign ser_done   = ser_strobe && (bit_q == 5'd0);
  assign id_valid   = id_valid_q;
  assign rd_ack     = rd_ack_q;
  assign rd_data    = rd_data_q;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    shadow_d   = shadow_q;
    id_valid_d = id_valid_q;
    pending_d  = pending_q | refresh;
    shift_d    = shift_q;
    bit_d      = bit_q;
    div_d      = div_q;
    rd_ack_d   = 1'b0;
    rd_data_d  = 32'd0;
    rd_armed_d = rd_armed_q;

    // A new ack needs rd_req to have been seen low since the previous one.
    if (((state_q == ST_IDLE) || (state_q == ST_SHIFT)) && rd_req && rd_armed_q) begin
      rd_ack_d   = 1'b1;
      rd_data_d  = shadow_q;
      rd_armed_d = 1'b0;
    end else if (!rd_req) begin
      rd_armed_d = 1'b1;
    end

    case (state_q)
      ST_WAIT: begin
        if (settle_q == SETTLE_LIM) begin
          state_d = ST_CAPTURE;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      ST_CAPTURE: begin
        shadow_d   = mask_rev;
        id_valid_d = 1'b1;
        pending_d  = refresh;
        state_d    = ST_IDLE;
      end
      ST_IDLE: begin
        if (pending_q || refresh) begin
          state_d = ST_CAPTURE;
        end else if (ser_start) begin
          state_d = ST_SHIFT;
          shift_d = shadow_q;
          bit_d   = 5'd31;
          div_d   = 8'd0;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d   = 8'd0;
          shift_d = {shift_q[30:0], 1'b0};
          bit_d   = bit_q - 5'd1;
          if (bit_q == 5'd0) begin
            state_d = ST_IDLE;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_WAIT;
      settle_q   <= 8'd0;
      shadow_q   <= 32'd0;
      id_valid_q <= 1'b0;
      pending_q  <= 1'b0;
      shift_q    <= 32'd0;
      bit_q      <= 5'd0;
      div_q      <= 8'd0;
      rd_ack_q   <= 1'b0;
      rd_data_q  <= 32'd0;
      rd_armed_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      shadow_q   <= shadow_d;
      id_valid_q <= id_valid_d;
      pending_q  <= pending_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      rd_ack_q   <= rd_ack_d;
      rd_data_q  <= rd_data_d;
      rd_armed_q <= rd_armed_d;
    end
  end

endmodule

// File: tb/tb_user_id_readout.sv
// Scoreboard bench for user_id_readout: a cycle-level behavioural model pushes expected
// acks and serial words; a negedge monitor pops and compares what the DUT presents.
module tb_user_id_readout;
  localparam int SETTLE = 4;
  localparam int DIV    = 2;
  localparam int XFER   = 32 * DIV;
  localparam int P_WAIT = 0, P_CAP = 1, P_IDLE = 2, P_SHIFT = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] mask_rev = 32'd0;
  logic        refresh = 1'b0, rd_req = 1'b0, ser_start = 1'b0;
  logic        id_valid, rd_ack, ser_busy, ser_out, ser_strobe, ser_done;
  logic [31:0] rd_data;

  user_id_readout #(.SETTLE_CYCLES(SETTLE), .CLKDIV(DIV)) dut (
    .clk(clk), .resetn(resetn), .mask_rev(mask_rev), .refresh(refresh),
    .id_valid(id_valid), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
    .ser_start(ser_start), .ser_busy(ser_busy), .ser_out(ser_out),
    .ser_strobe(ser_strobe), .ser_done(ser_done)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [31:0] data;} exp_t;
  exp_t rd_q[$];
  exp_t ser_q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model state: a transfer is a captured word plus elapsed clocks.
  int          cyc, m_phase, m_wait, m_elapsed;
  logic        m_valid, m_pending, m_armed;
  logic [31:0] m_shadow, m_word, col_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_phase = P_WAIT; m_wait = 0; m_elapsed = 0;
    m_valid = 1'b0; m_pending = 1'b0; m_armed = 1'b1;
    m_shadow = 32'd0; m_word = 32'd0; col_word = 32'd0;
    rd_q.delete(); ser_q.delete();
  endtask

  task automatic model_step();
    int   nphase;
    logic npend;
    cyc++;
    nphase = m_phase;
    npend  = m_pending | refresh;
    if ((m_phase == P_IDLE || m_phase == P_SHIFT) && rd_req && m_armed) begin
      rd_q.push_back(exp_t'{cyc, m_shadow});
      m_armed = 1'b0;
    end else if (!rd_req) begin
      m_armed = 1'b1;
    end
    case (m_phase)
      P_WAIT: if (m_wait == SETTLE) nphase = P_CAP; else m_wait++;
      P_CAP: begin
        m_shadow = mask_rev; m_valid = 1'b1; npend = refresh; nphase = P_IDLE;
      end
      P_IDLE: begin
        if (npend) nphase = P_CAP;
        else if (ser_start) begin
          nphase = P_SHIFT; m_word = m_shadow; m_elapsed = 0;
          ser_q.push_back(exp_t'{cyc + XFER - 1, m_shadow});
        end
      end
      default: if (m_elapsed == XFER - 1) nphase = P_IDLE; else m_elapsed++;
    endcase
    m_pending = npend;
    m_phase   = nphase;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!resetn) model_reset(); else model_step();
    end
  end

  // Monitor
  logic       e_busy, e_out, e_strb, e_done;
  exp_t       e;
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        e_busy = (m_phase == P_SHIFT);
        e_out  = e_busy ? m_word[31 - m_elapsed / DIV] : 1'b0;
        e_strb = e_busy && (m_elapsed % DIV == DIV - 1);
        e_done = e_busy && (m_elapsed == XFER - 1);
        chk("outputs{valid,busy,out,strobe,done}",
            {27'd0, id_valid, ser_busy, ser_out, ser_strobe, ser_done},
            {27'd0, m_valid, e_busy, e_out, e_strb, e_done});
        if (rd_ack) begin
          if (rd_q.size() == 0) chk("unexpected_rd_ack", 32'd1, 32'd0);
          else begin
            e = rd_q.pop_front();
            chk("rd_ack_cycle", cyc, e.cyc);
            chk("rd_data", rd_data, e.data);
          end
        end else begin
          chk("rd_data_idle_zero", rd_data, 32'd0);
          if (rd_q.size() != 0 && rd_q[0].cyc < cyc) begin
            e = rd_q.pop_front();
            chk("missing_rd_ack", 32'd0, 32'd1);
          end
        end
        if (ser_strobe) col_word = {col_word[30:0], ser_out};
        if (ser_done) begin
          if (ser_q.size() == 0) chk("unexpected_ser_done", 32'd1, 32'd0);
          else begin
            e = ser_q.pop_front();
            chk("ser_done_cycle", cyc, e.cyc);
            chk("ser_word", col_word, e.data);
          end
          col_word = 32'd0;
        end else if (ser_q.size() != 0 && ser_q[0].cyc < cyc) begin
          e = ser_q.pop_front();
          chk("missing_ser_done", 32'd0, 32'd1);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    model_reset();
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  task automatic do_read(output logic [31:0] d);
    int n = 0;
    logic got = 1'b0;
    d = 32'd0;
    rd_req = 1'b1;
    while (!got && n < 200) begin
      @(negedge clk);
      if (rd_ack) begin got = 1'b1; d = rd_data; end
      n++;
    end
    #1 rd_req = 1'b0;
    if (!got) chk("read_timeout", 32'd0, 32'd1);
    tick();
  endtask

  logic [31:0] rdv;
  int n, acks, busy_cnt;

  initial begin
    // Reset release and first capture timing.
    mask_rev = 32'hA5C3_0F81;
    repeat (3) tick();
    resetn = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 5) chk("id_valid_clock5", {31'd0, id_valid}, 32'd0);
      if (k == 6) chk("id_valid_clock6", {31'd0, id_valid}, 32'd1);
    end
    tick();
    do_read(rdv);
    chk("first_read", rdv, 32'hA5C3_0F81);

    // Read held from reset release: one ack only, after capture.
    rd_req = 1'b1;
    apply_reset();
    acks = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rd_ack) begin acks++; rdv = rd_data; end
    end
    #1 rd_req = 1'b0;
    chk("held_read_ack_count", acks, 1);
    chk("held_read_value", rdv, 32'hA5C3_0F81);
    tick();

    // Serial transfer with refresh and ignored starts mid-flight.
    mask_rev = 32'h8000_0001;
    refresh = 1'b1; tick(); refresh = 1'b0;
    repeat (4) tick();
    ser_start = 1'b1; tick(); ser_start = 1'b0;
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (ser_done) break;
      #1;
      ser_start = (n == 10);
      refresh   = (n == 20);
      if (n == 20) mask_rev = 32'h1234_5678;
    end
    chk("ser_done_clock", n, XFER);
    @(negedge clk);
    chk("busy_after_done", {31'd0, ser_busy}, 32'd0);
    #1 ser_start = 1'b1; tick(); ser_start = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (ser_busy) busy_cnt++;
    end
    #1;
    chk("start_at_idle_entry_dropped", busy_cnt, 0);
    do_read(rdv);
    chk("read_after_refresh", rdv, 32'h1234_5678);

    // Reset during bit 10 of a transfer.
    ser_start = 1'b1; tick(); ser_start = 1'b0;
    repeat (20) tick();
    chk("ser_out_before_abort", {31'd0, ser_out}, 32'd1);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("abort_outputs_zero", {28'd0, ser_busy, ser_out, ser_strobe, id_valid}, 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("recapture_after_abort", {31'd0, id_valid}, 32'd1);
    tick();
    do_read(rdv);
    chk("read_after_abort", rdv, 32'h1234_5678);

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      refresh   = ($urandom_range(0, 29) == 0);
      ser_start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) mask_rev = $urandom;
      if (rd_req && rd_ack) rd_req = 1'b0;
      else if (!rd_req && $urandom_range(0, 5) == 0) rd_req = 1'b1;
      if ($urandom_range(0, 999) == 0) begin
        refresh = 1'b0; ser_start = 1'b0; rd_req = 1'b0;
        apply_reset();
      end else begin
        tick();
      end
    end
    refresh = 1'b0; ser_start = 1'b0; rd_req = 1'b0;
    repeat (100) tick();
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("ser_queue_drained", ser_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
